// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_pkg
// Description : Shared state encodings and sequencer regime values.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ARM      = 3'd1;
    localparam state_t ST_START    = 3'd2;
    localparam state_t ST_WAIT_ACT = 3'd3;
    localparam state_t ST_RUN      = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // Regime values understood by control_path
    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_1   = 2'b01;
    localparam logic [1:0] MODE_2   = 2'b10;
    localparam logic [1:0] MODE_3   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin chooser.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant_vld,
    output logic       grant_idx
);

    // On a tie the requester that did not go last wins
    assign grant_vld = |valid;
    assign grant_idx = (valid == 2'b11) ? ~last : valid[1];

endmodule
`default_nettype wire

// File: rtl/dp_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dp_job_arbiter
// Description : Round-robin sharing of the control_path sequencer between two
//               job requesters, with completion pulses and a hang timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_job_arbiter
    import dp_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_mode,
    output logic       req0_ready,
    output logic       done0,
    input  logic       req1_valid,
    input  logic [1:0] req1_mode,
    output logic       req1_ready,
    output logic       done1,
    input  logic       dp_active,
    output logic [1:0] dp_on,
    output logic       dp_start,
    output logic       owner,
    output logic       timeout_err
);

    localparam int               TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] C_TMR_MAX = TMR_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_mode;
    logic             r_owner;
    logic             r_last;
    logic             r_tout;
    logic             w_grant_vld;
    logic             w_grant_idx;
    logic [1:0]       w_grant_mode;
    logic             w_idle;
    logic             w_busy;
    logic             w_expired;

    rr_pick2 u_pick (
        .valid     ({req1_valid, req0_valid}),
        .last      (r_last),
        .grant_vld (w_grant_vld),
        .grant_idx (w_grant_idx)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign w_busy       = (r_state == ST_ARM) || (r_state == ST_START) ||
                          (r_state == ST_WAIT_ACT) || (r_state == ST_RUN);
    assign w_grant_mode = w_grant_idx ? req1_mode : req0_mode;
    assign w_expired    = ((r_state == ST_WAIT_ACT) || (r_state == ST_RUN)) &&
                          (r_timer == C_TMR_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld)
                    w_state_nxt = (w_grant_mode == MODE_OFF) ? ST_DONE : ST_ARM;
            end
            ST_ARM:   w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_WAIT_ACT;
            // Expiry outranks an activity edge seen in the same cycle
            ST_WAIT_ACT: begin
                if (w_expired)      w_state_nxt = ST_DONE;
                else if (dp_active) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_expired || !dp_active) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_mode  <= MODE_OFF;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tout  <= w_expired;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_mode  <= w_grant_mode;
                        r_owner <= w_grant_idx;
                    end
                end
                ST_START:              r_timer <= '0;
                ST_WAIT_ACT, ST_RUN:   r_timer <= r_timer + 1'b1;
                ST_DONE:               r_last  <= r_owner;
                default: ;
            endcase
        end
    end

    assign req0_ready  = w_idle && w_grant_vld && !w_grant_idx;
    assign req1_ready  = w_idle && w_grant_vld &&  w_grant_idx;
    assign dp_on       = w_busy ? r_mode : MODE_OFF;
    assign dp_start    = (r_state == ST_START);
    assign done0       = (r_state == ST_DONE) && !r_owner;
    assign done1       = (r_state == ST_DONE) &&  r_owner;
    assign timeout_err = (r_state == ST_DONE) && r_tout;
    assign owner       = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dp_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_job_arbiter
// Description : Self-checking bench for dp_job_arbiter against a job-level
//               timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_job_arbiter;

    localparam int TIMEOUT = 63;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [1:0] req0_mode;
    logic       req0_ready;
    logic       done0;
    logic       req1_valid;
    logic [1:0] req1_mode;
    logic       req1_ready;
    logic       done1;
    logic       dp_active;
    logic [1:0] dp_on;
    logic       dp_start;
    logic       owner;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;
    bit m_last   = 1'b1;
    bit m_owner  = 1'b0;

    dp_job_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_mode   (req0_mode),
        .req0_ready  (req0_ready),
        .done0       (done0),
        .req1_valid  (req1_valid),
        .req1_mode   (req1_mode),
        .req1_ready  (req1_ready),
        .done1       (done1),
        .dp_active   (dp_active),
        .dp_on       (dp_on),
        .dp_start    (dp_start),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".dp_on"},    8'(dp_on),       8'd0);
        chk({tag, ".dp_start"}, 8'(dp_start),    8'd0);
        chk({tag, ".done0"},    8'(done0),       8'd0);
        chk({tag, ".done1"},    8'(done1),       8'd0);
        chk({tag, ".tout"},     8'(timeout_err), 8'd0);
        chk({tag, ".owner"},    8'(owner),       8'd0);
    endtask

    // Called at posedge+1 of an IDLE cycle. dly: cycles after cycle 3 before
    // the sequencer raises active; len: cycles active stays high.
    task automatic run_job(input bit v0, input bit v1, input logic [1:0] m0,
                           input logic [1:0] m1, input int dly, input int len,
                           input int rst_at);
        bit         idx;
        logic [1:0] md;
        int         a;
        int         t_done;
        bit         exp_to;
        idx    = (v0 && v1) ? ~m_last : v1;
        md     = idx ? m1 : m0;
        a      = 3 + dly;
        exp_to = 1'b0;
        if (md == 2'b00) begin
            t_done = 1;
        end else begin
            t_done = a + len + 1;
            if (TIMEOUT + 4 <= t_done) begin
                t_done = TIMEOUT + 4;
                exp_to = 1'b1;
            end
        end
        for (int c = 0; c <= t_done; c++) begin
            req0_valid = v0;
            req1_valid = v1;
            if (c == 0) begin
                req0_mode = m0;
                req1_mode = m1;
            end else begin
                req0_mode = 2'($urandom);
                req1_mode = 2'($urandom);
            end
            dp_active = (md != 2'b00) && (c >= a) && (c < a + len);
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1 chk_quiet("rst_mid");
                @(posedge clk); #1;
                chk_quiet("rst_hold");
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                dp_active  = 1'b0;
                @(negedge clk) rst = 1'b0;
                @(posedge clk); #1;
                chk("rst_after.ready0", 8'(req0_ready), 8'd0);
                m_last  = 1'b1;
                m_owner = 1'b0;
                return;
            end
            #1;
            chk("ready0",   8'(req0_ready),  8'(c == 0 && idx == 1'b0));
            chk("ready1",   8'(req1_ready),  8'(c == 0 && idx == 1'b1));
            chk("dp_on",    8'(dp_on),       8'((md != 2'b00 && c >= 1 && c < t_done) ? md : 2'b00));
            chk("dp_start", 8'(dp_start),    8'(md != 2'b00 && c == 2));
            chk("done0",    8'(done0),       8'(c == t_done && idx == 1'b0));
            chk("done1",    8'(done1),       8'(c == t_done && idx == 1'b1));
            chk("tout",     8'(timeout_err), 8'(c == t_done && exp_to));
            chk("owner",    8'(owner),       8'((c == 0) ? m_owner : idx));
            @(posedge clk); #1;
        end
        m_last  = idx;
        m_owner = idx;
    endtask

    initial begin
        bit         v0;
        bit         v1;
        int         len;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_mode  = 2'b00;
        req1_mode  = 2'b00;
        dp_active  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset.ready0", 8'(req0_ready), 8'd0);
        chk("reset.ready1", 8'(req1_ready), 8'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Single job, active for 5 cycles
        run_job(1, 0, 2'b10, 2'b00, 1, 5, -1);
        // Contention with alternating grants
        repeat (4) run_job(1, 1, 2'b01, 2'b11, 0, 3, -1);
        // Sequencer never responds
        run_job(1, 0, 2'b01, 2'b00, 1000, 0, -1);
        // Sequencer stuck active, then the other queued requester
        run_job(1, 1, 2'b01, 2'b11, 0, 1000, -1);
        run_job(1, 1, 2'b01, 2'b11, 0, 2, -1);
        // No-op job
        run_job(0, 1, 2'b00, 2'b00, 0, 0, -1);
        run_job(0, 1, 2'b11, 2'b00, 0, 0, -1);
        // Asynchronous reset during RUN, then a tie
        run_job(1, 1, 2'b11, 2'b01, 0, 20, 6);
        run_job(1, 1, 2'b10, 2'b01, 0, 2, -1);

        for (int j = 0; j < 24; j++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            len = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(1, 8));
            run_job(v0, v1, 2'($urandom), 2'($urandom),
                    int'($urandom_range(0, 4)), len, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
